// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with wrap/saturate, tc and wrap pulse
// Optional wrap_cnt output is enabled by defining COUNTER_WRAP_CNT_EN.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef COUNTER_WRAP_CNT_EN
  ,
  output logic [WIDTH-1:0] wrap_cnt
`endif
);

  if (WIDTH < 1 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_params
    $error("updown_mod_counter: MOD must be in 2..2**WIDTH and WIDTH >= 1");
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);

  logic [WIDTH:0]   inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // Increment is one bit wider so MOD == 2**WIDTH reaches MOD without overflowing.
  assign inc          = {1'b0, count} + 1'b1;
  assign dec          = count - 1'b1;
  assign at_max       = (inc == MOD_W);
  assign at_zero      = (count == '0);
  assign load_clamped = ({1'b0, load_val} >= MOD_W) ? MAX_C : load_val;
  assign tc           = en & (up ? at_max : at_zero);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_clamped;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          next_count = inc[WIDTH-1:0];
        end else if (SATURATE == 0) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          next_count = dec;
        end else if (SATURATE == 0) begin
          next_count = MAX_C;
          next_wrap  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

`ifdef COUNTER_WRAP_CNT_EN
  // Counts wrap pulses in step with wrap itself, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      wrap_cnt <= '0;
    end else if (next_wrap && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for updown_mod_counter over four configurations
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count [4];
  logic       tc    [4];
  logic       wrap  [4];
`ifdef COUNTER_WRAP_CNT_EN
  logic [3:0] wcnt  [4];
`endif

  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count[0]), .tc(tc[0]), .wrap(wrap[0])
`ifdef COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wcnt[0])
`endif
  );
  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count[1]), .tc(tc[1]), .wrap(wrap[1])
`ifdef COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wcnt[1])
`endif
  );
  updown_mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count[2]), .tc(tc[2]), .wrap(wrap[2])
`ifdef COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wcnt[2])
`endif
  );
  updown_mod_counter #(.WIDTH(4), .MOD(2), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count[3]), .tc(tc[3]), .wrap(wrap[3])
`ifdef COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wcnt[3])
`endif
  );

  typedef struct packed {
    logic [3:0] c;
    logic       w;
    logic       t;
    logic [3:0] wc;
  } lane_t;

  lane_t [3:0] q[$];

  int mods [4] = '{10, 10, 16, 2};
  int sats [4] = '{0, 1, 0, 0};
  int mc   [4];
  int mw   [4];
  int mwc  [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference: counter rules stated in terms of integer range 0..MOD-1.
  task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int lv);
    lane_t [3:0] ex;
    int nw;
    rst = r; en = e; up = u; load = l; load_val = 4'(lv);
    for (int i = 0; i < 4; i++) begin
      ex[i].c  = 4'(mc[i]);
      ex[i].w  = (mw[i] != 0);
      ex[i].t  = e && (u ? (mc[i] == mods[i] - 1) : (mc[i] == 0));
      ex[i].wc = 4'(mwc[i]);
    end
    q.push_back(ex);
    for (int i = 0; i < 4; i++) begin
      nw = 0;
      if (r) begin
        mc[i] = 0; mwc[i] = 0;
      end else if (l) begin
        mc[i] = (lv >= mods[i]) ? mods[i] - 1 : lv;
        mwc[i] = 0;
      end else if (e) begin
        if (u) begin
          if (mc[i] + 1 < mods[i]) mc[i] = mc[i] + 1;
          else if (sats[i] == 0) begin mc[i] = 0; nw = 1; end
        end else begin
          if (mc[i] > 0) mc[i] = mc[i] - 1;
          else if (sats[i] == 0) begin mc[i] = mods[i] - 1; nw = 1; end
        end
      end
      if (nw != 0 && mwc[i] < 15) mwc[i] = mwc[i] + 1;
      mw[i] = nw;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    lane_t [3:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("count", i, count[i], e[i].c);
        chk("wrap", i, {3'b0, wrap[i]}, {3'b0, e[i].w});
        chk("tc", i, {3'b0, tc[i]}, {3'b0, e[i].t});
`ifdef COUNTER_WRAP_CNT_EN
        chk("wrap_cnt", i, wcnt[i], e[i].wc);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      mc[i] = 0; mw[i] = 0; mwc[i] = 0;
    end
    // reset held two edges with en/up high, then free count up across the wrap
    cycle(1, 1, 1, 0, 0);
    repeat (12) cycle(0, 1, 1, 0, 0);
    // down count from zero
    cycle(1, 0, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);
    // long up run into saturation, then back down
    cycle(1, 0, 0, 0, 0);
    repeat (15) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // load priority, clamping, and reset over load
    cycle(0, 1, 1, 1, 7);
    cycle(0, 1, 1, 1, 12);
    cycle(1, 1, 1, 1, 3);
    cycle(0, 0, 0, 0, 0);
    // reset pulse mid-count
    cycle(0, 0, 0, 1, 5);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    repeat (3) cycle(0, 1, 1, 0, 0);
    // randomized mix
    repeat (800) begin
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 15)));
    end
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
